// File: rtl/wb_stream_loader_if.sv
// Bus bundles for wb_stream_loader: byte stream (valid/ready) and Wishbone B4 pipelined.
// Signal names follow the loader's pin list so both sides read the same.

interface wb_stream_loader_stream_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

interface wb_stream_loader_wb_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_stall_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, output wb_stb_o, output wb_we_o, output wb_sel_o,
    output wb_adr_o, output wb_dat_o,
    input  wb_dat_i, input wb_stall_i, input wb_ack_i
  );
  modport slave (
    input  wb_cyc_o, input wb_stb_o, input wb_we_o, input wb_sel_o,
    input  wb_adr_o, input wb_dat_o,
    output wb_dat_i, output wb_stall_i, output wb_ack_i
  );
endinterface

// File: rtl/wb_stream_loader.sv
// Stream-to-Wishbone image loader: parses a length-prefixed byte stream and writes
// each little-endian word to consecutive addresses, one outstanding transaction at a time.

module wb_stream_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  wb_stream_loader_stream_if.slave       s,
  wb_stream_loader_wb_if.master          wb,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_REQ,
    ST_ACK,
    ST_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [23:0]          hdr_q, hdr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 fire_c;
  logic [31:0]          hdr_word_c;
  logic [CNT_WIDTH-1:0] cnt_sat_c;
  logic                 unused_c;

  assign fire_c     = s.s_valid & rdy_q;
  // Completed header once the 4th byte lands: earlier bytes already sit in hdr_q.
  assign hdr_word_c = {s.s_data, hdr_q};
  assign cnt_sat_c  = (64'(hdr_word_c) > 64'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(hdr_word_c);
  assign unused_c   = ^wb.wb_dat_i;

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (fire_c) begin
          idx_d = idx_q + 2'd1;
          hdr_d = {s.s_data, hdr_q[23:8]};
          if (idx_q == 2'd3) begin
            hdr_d = '0;
            if (hdr_word_c == 32'd0) begin
              state_d = ST_FIN;
            end else begin
              cnt_d   = cnt_sat_c;
              adr_d   = BASE_ADDR;
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (fire_c) begin
          idx_d = idx_q + 2'd1;
          dat_d = {s.s_data, dat_q[31:8]};
          if (idx_q == 2'd3) begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (!wb.wb_stall_i) begin
          stb_d   = 1'b0;
          tmo_d   = '0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Ack wins over a timeout expiring on the same edge.
        if (wb.wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = cnt_q - CNT_ONE;
          adr_d   = adr_q + 32'd4;
          state_d = (cnt_q == CNT_ONE) ? ST_FIN : ST_DATA;
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          idx_d   = 2'd0;
          hdr_d   = '0;
          cnt_d   = '0;
          adr_d   = BASE_ADDR;
          state_d = ST_HDR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_HDR;
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase

    rdy_d  = (state_d == ST_HDR) || (state_d == ST_DATA);
    busy_d = (state_d != ST_HDR) || (idx_d != 2'd0);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HDR;
      idx_q   <= 2'd0;
      hdr_q   <= '0;
      cnt_q   <= '0;
      adr_q   <= BASE_ADDR;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      tmo_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      tmo_q   <= tmo_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s.s_ready   = rdy_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_wb_stream_loader.sv
// Directed bench for wb_stream_loader: a scripted Wishbone responder plus per-scenario tasks.
// Built with ACK_TIMEOUT=8 and CNT_WIDTH=2 so timeout and count saturation are cheap to reach.

module tb_wb_stream_loader;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stream_loader_stream_if sif ();
  wb_stream_loader_wb_if     wbi ();

  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       resp_stall = 1'b0;
  logic       resp_ack   = 1'b0;
  logic       stray_ack  = 1'b0;
  logic       busy, done, err;

  assign sif.s_valid    = s_valid;
  assign sif.s_data     = s_data;
  assign wbi.wb_stall_i = resp_stall;
  assign wbi.wb_ack_i   = resp_ack | stray_ack;
  assign wbi.wb_dat_i   = 32'h0;

  wb_stream_loader #(.BASE_ADDR(BASE), .ACK_TIMEOUT(8), .CNT_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sif),
    .wb    (wbi),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  int checks = 0;
  int fails  = 0;

  // Responder configuration and observations
  int  stall_cfg = 0;
  int  ack_delay = 0;
  bit  ack_en    = 1'b1;
  int  cycle_cnt = 0;
  int  done_cnt, err_cnt, rdy_viol, cyc_cycles, acc_cnt, stall_seen, stab_err, log_bad;
  int  acc_cyc, drop_cyc;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];

  bit  pending, in_req, prev_cyc;
  int  ack_left, stall_left;
  logic [31:0] ref_adr, ref_dat;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Responder and monitor, both acting half a cycle away from the DUT's edge
  always @(negedge clk) begin
    if (!rst_n) begin
      resp_stall = 1'b0;
      resp_ack   = 1'b0;
      pending    = 1'b0;
      in_req     = 1'b0;
      prev_cyc   = 1'b0;
    end else begin
      resp_ack = 1'b0;
      if (pending) begin
        if (ack_left == 0) begin
          resp_ack = 1'b1;
          pending  = 1'b0;
        end else begin
          ack_left--;
        end
      end
      if (wbi.wb_cyc_o && wbi.wb_stb_o) begin
        if (!in_req) begin
          in_req     = 1'b1;
          stall_left = stall_cfg;
          ref_adr    = wbi.wb_adr_o;
          ref_dat    = wbi.wb_dat_o;
        end else if (wbi.wb_adr_o !== ref_adr || wbi.wb_dat_o !== ref_dat) begin
          stab_err++;
        end
        if (stall_left > 0) begin
          resp_stall = 1'b1;
          stall_left--;
          stall_seen++;
        end else begin
          resp_stall = 1'b0;
          in_req     = 1'b0;
          acc_cnt++;
          acc_cyc = cycle_cnt + 1;
          log_adr.push_back(wbi.wb_adr_o);
          log_dat.push_back(wbi.wb_dat_o);
          if (wbi.wb_sel_o !== 4'hF || wbi.wb_we_o !== 1'b1) log_bad++;
          if (ack_en) begin
            pending  = 1'b1;
            ack_left = ack_delay;
          end
        end
      end else begin
        resp_stall = 1'b0;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (sif.s_ready && wbi.wb_cyc_o) rdy_viol++;
      if (wbi.wb_cyc_o) cyc_cycles++;
      if (prev_cyc && !wbi.wb_cyc_o) drop_cyc = cycle_cnt;
      prev_cyc = wbi.wb_cyc_o;
    end
  end

  task automatic clear_stats();
    @(posedge clk);
    #1;
    done_cnt = 0; err_cnt = 0; rdy_viol = 0; cyc_cycles = 0; acc_cnt = 0;
    stall_seen = 0; stab_err = 0; log_bad = 0; acc_cyc = 0; drop_cyc = 0;
    log_adr.delete();
    log_dat.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!sif.s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++; fails++;
      $display("FAIL send_byte: s_ready stuck low for %0d cycles, required 1", t);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic end_stream();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || wbi.wb_cyc_o) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++; fails++;
      $display("FAIL wait_idle: busy=%b cyc=%b after %0d cycles, required idle", busy, wbi.wb_cyc_o, t);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sif.s_ready !== 1'b1) begin fails++; $display("FAIL rst_s_ready: got %b exp 1", sif.s_ready); end
    checks++; if (wbi.wb_cyc_o !== 1'b0 || wbi.wb_stb_o !== 1'b0 || wbi.wb_we_o !== 1'b0) begin
      fails++; $display("FAIL rst_bus: cyc/stb/we got %b%b%b exp 000", wbi.wb_cyc_o, wbi.wb_stb_o, wbi.wb_we_o); end
    checks++; if (wbi.wb_adr_o !== BASE) begin fails++; $display("FAIL rst_adr: got %h exp %h", wbi.wb_adr_o, BASE); end
    checks++; if (wbi.wb_dat_o !== 32'h0) begin fails++; $display("FAIL rst_dat: got %h exp 0", wbi.wb_dat_o); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL rst_flags: busy/done/err got %b%b%b exp 000", busy, done, err); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (sif.s_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_release: s_ready=%b busy=%b exp 1/0", sif.s_ready, busy); end
  endtask

  task automatic test_single();
    clear_stats();
    send_word(32'h1); send_word(32'hDEAD_BEEF); end_stream(); wait_idle();
    checks++; if (acc_cnt !== 1) begin fails++; $display("FAIL single_count: got %0d exp 1", acc_cnt); end
    if (log_adr.size() > 0) begin
      checks++; if (log_adr[0] !== BASE) begin fails++; $display("FAIL single_adr: got %h exp %h", log_adr[0], BASE); end
      checks++; if (log_dat[0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL single_dat: got %h exp deadbeef", log_dat[0]); end
    end
    checks++; if (log_bad !== 0) begin fails++; $display("FAIL single_sel_we: %0d bad requests exp 0", log_bad); end
    checks++; if (done_cnt !== 1) begin fails++; $display("FAIL single_done: got %0d exp 1", done_cnt); end
    checks++; if (rdy_viol !== 0) begin fails++; $display("FAIL single_ready: s_ready high in %0d bus cycles exp 0", rdy_viol); end
  endtask

  task automatic test_multi();
    logic [31:0] exp_dat[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    clear_stats();
    send_word(32'h3);
    for (int i = 0; i < 3; i++) send_word(exp_dat[i]);
    end_stream(); wait_idle();
    checks++; if (acc_cnt !== 3) begin fails++; $display("FAIL multi_count: got %0d exp 3", acc_cnt); end
    for (int i = 0; i < 3 && i < log_adr.size(); i++) begin
      checks++; if (log_adr[i] !== BASE + 32'(4 * i) || log_dat[i] !== exp_dat[i]) begin
        fails++; $display("FAIL multi_write%0d: got %h/%h exp %h/%h", i, log_adr[i], log_dat[i], BASE + 32'(4 * i), exp_dat[i]); end
    end
    checks++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL multi_done: done=%0d err=%0d exp 1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_stall();
    clear_stats();
    stall_cfg = 5; ack_delay = 5;
    send_word(32'h1); send_word(32'hA5A5_5A5A); end_stream(); wait_idle();
    stall_cfg = 0; ack_delay = 0;
    checks++; if (stall_seen !== 5) begin fails++; $display("FAIL stall_cycles: got %0d exp 5", stall_seen); end
    checks++; if (stab_err !== 0) begin fails++; $display("FAIL stall_stable: %0d changes exp 0", stab_err); end
    checks++; if (acc_cnt !== 1) begin fails++; $display("FAIL stall_accept: got %0d exp 1", acc_cnt); end
    checks++; if (err_cnt !== 0 || done_cnt !== 1) begin fails++; $display("FAIL stall_result: err=%0d done=%0d exp 0/1", err_cnt, done_cnt); end
  endtask

  task automatic test_ack_at_timeout();
    clear_stats();
    ack_delay = 7;
    send_word(32'h1); send_word(32'h0BAD_F00D); end_stream(); wait_idle();
    ack_delay = 0;
    checks++; if (err_cnt !== 0 || done_cnt !== 1) begin fails++; $display("FAIL late_ack: err=%0d done=%0d exp 0/1", err_cnt, done_cnt); end
  endtask

  task automatic test_timeout();
    clear_stats();
    ack_en = 1'b0;
    send_word(32'h1); send_word(32'h1234_5678); end_stream(); wait_idle();
    ack_en = 1'b1;
    checks++; if (err_cnt !== 1 || done_cnt !== 0) begin fails++; $display("FAIL tmo_flags: err=%0d done=%0d exp 1/0", err_cnt, done_cnt); end
    checks++; if (drop_cyc - acc_cyc !== 8) begin fails++; $display("FAIL tmo_delay: cyc dropped %0d cycles after accept exp 8", drop_cyc - acc_cyc); end
    clear_stats();
    send_word(32'h1); send_word(32'hCAFE_F00D); end_stream(); wait_idle();
    checks++; if (acc_cnt !== 1 || log_adr.size() != 1) begin fails++; $display("FAIL tmo_next_count: got %0d exp 1", acc_cnt); end
    else begin
      checks++; if (log_adr[0] !== BASE || log_dat[0] !== 32'hCAFE_F00D) begin
        fails++; $display("FAIL tmo_next_write: got %h/%h exp %h/cafef00d", log_adr[0], log_dat[0], BASE); end
    end
    checks++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL tmo_next_done: done=%0d err=%0d exp 1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_zero();
    clear_stats();
    send_word(32'h0); end_stream(); wait_idle();
    checks++; if (done_cnt !== 1) begin fails++; $display("FAIL zero_done: got %0d exp 1", done_cnt); end
    checks++; if (cyc_cycles !== 0) begin fails++; $display("FAIL zero_bus: cyc high %0d cycles exp 0", cyc_cycles); end
  endtask

  task automatic test_saturate();
    clear_stats();
    send_word(32'h5);
    for (int i = 0; i < 3; i++) send_word(32'h0A0B_0C00 + 32'(i));
    end_stream(); wait_idle();
    checks++; if (acc_cnt !== 3 || done_cnt !== 1) begin fails++; $display("FAIL sat_count: writes=%0d done=%0d exp 3/1", acc_cnt, done_cnt); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL sat_idle: busy got %b exp 0", busy); end
    if (log_adr.size() == 3) begin
      checks++; if (log_adr[2] !== BASE + 32'd8 || log_dat[2] !== 32'h0A0B_0C02) begin
        fails++; $display("FAIL sat_last: got %h/%h exp %h/0a0b0c02", log_adr[2], log_dat[2], BASE + 32'd8); end
    end
  endtask

  task automatic test_stray_ack();
    clear_stats();
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    checks++; if (busy !== 1'b0 || wbi.wb_cyc_o !== 1'b0) begin fails++; $display("FAIL stray_idle: busy=%b cyc=%b exp 0/0", busy, wbi.wb_cyc_o); end
    send_word(32'h1);
    send_byte(8'h44); send_byte(8'h33);
    stray_ack = 1'b1;
    send_byte(8'h22);
    stray_ack = 1'b0;
    send_byte(8'h11); end_stream(); wait_idle();
    checks++; if (acc_cnt !== 1 || done_cnt !== 1) begin fails++; $display("FAIL stray_count: writes=%0d done=%0d exp 1/1", acc_cnt, done_cnt); end
    if (log_dat.size() > 0) begin
      checks++; if (log_dat[0] !== 32'h1122_3344 || log_adr[0] !== BASE) begin
        fails++; $display("FAIL stray_write: got %h/%h exp %h/11223344", log_adr[0], log_dat[0], BASE); end
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    clear_stats();
    send_word(32'h2); send_word(32'h7777_0001);
    send_byte(8'h02);
    ack_en = 1'b0;
    send_byte(8'h00); send_byte(8'h77); send_byte(8'h77); end_stream();
    while (acc_cnt < 2 && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    checks++; if (wbi.wb_cyc_o !== 1'b1 || wbi.wb_adr_o !== BASE + 32'd4) begin
      fails++; $display("FAIL mid_pre: cyc=%b adr=%h exp 1/%h", wbi.wb_cyc_o, wbi.wb_adr_o, BASE + 32'd4); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wbi.wb_cyc_o !== 1'b0 || wbi.wb_stb_o !== 1'b0) begin
      fails++; $display("FAIL mid_reset_bus: cyc/stb got %b%b exp 00", wbi.wb_cyc_o, wbi.wb_stb_o); end
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    checks++; if (sif.s_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b exp 1", sif.s_ready); end
    clear_stats();
    send_word(32'h1); send_word(32'h5A5A_5A5A); end_stream(); wait_idle();
    checks++; if (log_adr.size() != 1 || done_cnt !== 1) begin fails++; $display("FAIL mid_fresh_count: writes=%0d done=%0d exp 1/1", log_adr.size(), done_cnt); end
    else begin
      checks++; if (log_adr[0] !== BASE || log_dat[0] !== 32'h5A5A_5A5A) begin
        fails++; $display("FAIL mid_fresh_write: got %h/%h exp %h/5a5a5a5a", log_adr[0], log_dat[0], BASE); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_ack_at_timeout();
    test_timeout();
    test_zero();
    test_saturate();
    test_stray_ack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
